// File: rtl/sdp_ram_stream_fifo_ctrl.sv
// Stream FIFO controller around an external simple-dual-port RAM with 1-cycle read latency.
// A 2-entry output buffer absorbs the read latency so the stream runs at one word per cycle.
module sdp_ram_stream_fifo_ctrl #(
    parameter int C_RAM_WIDTH = 64,
    parameter int C_RAM_DEPTH = 512,
    localparam int AW = $clog2(C_RAM_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [C_RAM_WIDTH-1:0] in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [C_RAM_WIDTH-1:0] out_data,
    input  logic                   out_ready,
    output logic [AW-1:0]          ram_wrAddr,
    output logic [C_RAM_WIDTH-1:0] ram_datain,
    output logic                   ram_wren,
    output logic [AW-1:0]          ram_rdAddr,
    output logic                   ram_rden,
    input  logic [C_RAM_WIDTH-1:0] ram_dataout,
    output logic [AW+1:0]          level
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_t;

    localparam logic [AW:0]   DEPTH_C = C_RAM_DEPTH[AW:0];
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

    buf_state_t             state_r, state_s;
    logic [AW-1:0]          wr_ptr_r, rd_ptr_r;
    logic [AW:0]            ram_cnt_r;
    logic                   inflight_r;
    logic [C_RAM_WIDTH-1:0] buf0_r, buf1_r, buf0_s, buf1_s;
    logic [1:0]             buf_cnt_s;
    logic                   push_s, pop_s, wren_s, rden_s;

    // buf0 always holds the oldest word; a push in the cycle of a pop refills the head slot.
    assign push_s = inflight_r;
    assign pop_s  = (state_r != EMPTY) && out_ready;
    assign wren_s = in_valid && (ram_cnt_r < DEPTH_C);
    assign rden_s = (ram_cnt_r != {(AW+1){1'b0}}) &&
                    (({1'b0, buf_cnt_s} + {2'b00, inflight_r}) < (3'd2 + {2'b00, pop_s}));

    assign in_ready   = (ram_cnt_r < DEPTH_C);
    assign ram_wren   = wren_s;
    assign ram_wrAddr = wr_ptr_r;
    assign ram_datain = in_data;
    assign ram_rden   = rden_s;
    assign ram_rdAddr = rd_ptr_r;
    assign out_valid  = (state_r != EMPTY);
    assign out_data   = buf0_r;
    assign level      = {1'b0, ram_cnt_r} + {{(AW+1){1'b0}}, inflight_r} + {{AW{1'b0}}, buf_cnt_s};

    // Occupancy of the output buffer decoded from its state.
    always_comb begin
        buf_cnt_s = 2'd0;
        case (state_r)
            EMPTY:   buf_cnt_s = 2'd0;
            ONE:     buf_cnt_s = 2'd1;
            TWO:     buf_cnt_s = 2'd2;
            default: buf_cnt_s = 2'd0;
        endcase
    end

    // Output buffer next state and contents.
    always_comb begin
        state_s = state_r;
        buf0_s  = buf0_r;
        buf1_s  = buf1_r;
        case (state_r)
            EMPTY: begin
                if (push_s) begin
                    state_s = ONE;
                    buf0_s  = ram_dataout;
                end else begin
                    state_s = EMPTY;
                end
            end
            ONE: begin
                if (push_s && pop_s) begin
                    buf0_s = ram_dataout;
                end else if (push_s) begin
                    state_s = TWO;
                    buf1_s  = ram_dataout;
                end else if (pop_s) begin
                    state_s = EMPTY;
                end else begin
                    state_s = ONE;
                end
            end
            TWO: begin
                if (pop_s) begin
                    buf0_s = buf1_r;
                    if (push_s) begin
                        buf1_s = ram_dataout;
                    end else begin
                        state_s = ONE;
                    end
                end else begin
                    state_s = TWO;
                end
            end
            default: state_s = EMPTY;
        endcase
    end

    // Pointer, count, in-flight and buffer registers; reset discards everything held.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            ram_cnt_r  <= {(AW+1){1'b0}};
            inflight_r <= 1'b0;
            state_r    <= EMPTY;
            buf0_r     <= {C_RAM_WIDTH{1'b0}};
            buf1_r     <= {C_RAM_WIDTH{1'b0}};
        end else begin
            if (wren_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (rden_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
            ram_cnt_r  <= ram_cnt_r + {{AW{1'b0}}, wren_s} - {{AW{1'b0}}, rden_s};
            inflight_r <= rden_s;
            state_r    <= state_s;
            buf0_r     <= buf0_s;
            buf1_r     <= buf1_s;
        end
    end

endmodule

// File: tb/tb_sdp_ram_stream_fifo_ctrl.sv
// Directed bench for sdp_ram_stream_fifo_ctrl (depth 4, width 8) with a queue-based
// scoreboard that checks level, output order, stall stability and RAM addressing every cycle.
module tb_sdp_ram_stream_fifo_ctrl;

    localparam int W = 8;
    localparam int D = 4;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = 8'h00;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready = 1'b0;
    logic [AW-1:0] ram_wrAddr, ram_rdAddr;
    logic [W-1:0]  ram_datain, ram_dataout;
    logic          ram_wren, ram_rden;
    logic [AW+1:0] level;

    int n_cmp = 0;
    int n_err = 0;
    bit started = 1'b0;

    sdp_ram_stream_fifo_ctrl #(.C_RAM_WIDTH(W), .C_RAM_DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .ram_wrAddr(ram_wrAddr), .ram_datain(ram_datain), .ram_wren(ram_wren),
        .ram_rdAddr(ram_rdAddr), .ram_rden(ram_rden), .ram_dataout(ram_dataout),
        .level(level)
    );

    always #5 clk = ~clk;

    // Read-first RAM, data one cycle after the read strobe.
    logic [W-1:0] mem [0:D-1];
    always @(posedge clk) begin
        if (ram_wren) mem[ram_wrAddr] <= ram_datain;
        if (ram_rden) ram_dataout <= mem[ram_rdAddr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: words held = accepted - delivered; delivered in acceptance order.
    logic [W-1:0] q[$];
    int           n_wr = 0;
    int           n_rd = 0;
    bit           hold = 1'b0;
    logic [W-1:0] hold_data;

    always @(negedge clk) begin
        if (started) begin
            check("level", 32'(level), 32'(q.size()));
            check("wren", 32'(ram_wren), 32'(in_valid && in_ready));
            if (ram_wren) begin
                check("wr_addr", 32'(ram_wrAddr), 32'(n_wr % D));
                check("datain", 32'(ram_datain), 32'(in_data));
            end
            if (ram_rden) check("rd_addr", 32'(ram_rdAddr), 32'(n_rd % D));
            if (hold) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(hold_data));
            end
            if (out_valid && out_ready) begin
                check("pop_nonempty", 32'(q.size() > 0), 32'd1);
                if (q.size() > 0) check("out_order", 32'(out_data), 32'(q[0]));
            end
            if (rst) begin
                q.delete();
                n_wr = 0;
                n_rd = 0;
                hold = 1'b0;
            end else begin
                if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
                if (in_valid && in_ready) q.push_back(in_data);
                if (ram_wren) n_wr++;
                if (ram_rden) n_rd++;
                hold = out_valid && !out_ready;
                hold_data = out_data;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int sent, popped, n_out, first_c, last_c;
        bit acc, pp;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        started = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_wren", 32'(ram_wren), 32'd0);
        check("rst_rden", 32'(ram_rden), 32'd0);

        // Single word latency
        in_valid = 1'b1; in_data = 8'h11; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        #1;
        check("t1_rden", 32'(ram_rden), 32'd1);
        check("t1_level_a", 32'(level), 32'd1);
        check("t1_valid_a", 32'(out_valid), 32'd0);
        step();
        check("t1_valid_b", 32'(out_valid), 32'd0);
        check("t1_level_b", 32'(level), 32'd1);
        step();
        check("t1_valid_c", 32'(out_valid), 32'd1);
        check("t1_data", 32'(out_data), 32'h11);
        step();
        check("t1_valid_d", 32'(out_valid), 32'd0);
        check("t1_level_d", 32'(level), 32'd0);

        // Fill with downstream stalled
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_data = 8'(8'hA0 + i);
            #1;
            check("t2_in_ready", 32'(in_ready), 32'd1);
            step();
        end
        in_data = 8'hA6;
        #1;
        check("t2_full_ready", 32'(in_ready), 32'd0);
        check("t2_level", 32'(level), 32'd6);
        step();
        check("t2_full_ready2", 32'(in_ready), 32'd0);
        check("t2_level2", 32'(level), 32'd6);
        check("t2_head", 32'(out_data), 32'hA0);
        in_valid = 1'b0;

        // Drain from full
        out_ready = 1'b1;
        #1;
        check("t3_ready_before", 32'(in_ready), 32'd0);
        check("t3_rden_first", 32'(ram_rden), 32'd1);
        for (int k = 0; k < 6; k++) begin
            check("t3_valid", 32'(out_valid), 32'd1);
            check("t3_data", 32'(out_data), 32'(8'hA0 + k));
            step();
            if (k == 0) check("t3_ready_after", 32'(in_ready), 32'd1);
        end
        check("t3_empty", 32'(out_valid), 32'd0);
        check("t3_level", 32'(level), 32'd0);

        // Continuous streaming, pointer wrap
        n_out = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 40; c++) begin
            in_valid = (c < 20);
            in_data = 8'(8'h30 + c);
            #1;
            if (c < 20) check("t4_in_ready", 32'(in_ready), 32'd1);
            step();
            if (out_valid) begin
                check("t4_data", 32'(out_data), 32'(8'h30 + n_out));
                if (first_c < 0) first_c = c;
                last_c = c;
                n_out++;
            end
        end
        check("t4_count", 32'(n_out), 32'd20);
        check("t4_first", 32'(first_c), 32'd2);
        check("t4_last", 32'(last_c), 32'd21);

        // Back-pressure with gaps on input
        sent = 0; popped = 0;
        for (int c = 0; c < 3000 && popped < 200; c++) begin
            in_valid = (sent < 200) && (c % 7 != 3);
            in_data = 8'(sent * 37) ^ 8'h5C;
            out_ready = ((c * 13) % 11) < 6;
            #1;
            acc = in_valid && in_ready;
            pp = out_valid && out_ready;
            step();
            if (acc) sent++;
            if (pp) popped++;
        end
        in_valid = 1'b0;
        check("t5_popped", 32'(popped), 32'd200);
        check("t5_sent", 32'(sent), 32'd200);
        check("t5_level", 32'(level), 32'd0);

        // Reset mid-transfer
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 8'(8'hB0 + i);
            step();
        end
        in_valid = 1'b0;
        #1;
        check("t6_level5", 32'(level), 32'd5);
        out_ready = 1'b1;
        #1;
        check("t6_rden", 32'(ram_rden), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("t6_level0", 32'(level), 32'd0);
        check("t6_valid0", 32'(out_valid), 32'd0);
        check("t6_in_ready", 32'(in_ready), 32'd1);
        check("t6_rden0", 32'(ram_rden), 32'd0);
        step();
        check("t6_stale_ignored", 32'(out_valid), 32'd0);
        in_valid = 1'b1; in_data = 8'h5A;
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 8 && !out_valid; c++) step();
        check("t6_first_valid", 32'(out_valid), 32'd1);
        check("t6_first_data", 32'(out_data), 32'h5A);
        repeat (3) step();
        check("t6_final_level", 32'(level), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
